// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Byte sink for the cache-counter ASCII report stream. Bytes written by the
// counter stage are buffered in a circular FIFO and drained as 8N1 frames
// (start bit, 8 data bits LSB first, stop bit) on a UART TX pin. The
// producer gets no backpressure. A byte that cannot be stored is dropped,
// and the sticky overflow flag records the loss.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit
//   DEPTH         FIFO entries (power of two)
//   ADDR_W        log2(DEPTH)
//   WR_LAG        1: write strobe is wr_en delayed one cycle; 0: wr_en itself
//   EOL_EN        1: append 0x0D,0x0A after every write burst
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   wr_en       in   producer write enable (burst flag)
//   data_i      in   producer byte
//   tx          out  UART serial output, idle high (registered)
//   busy        out  frame on the line or FIFO non-empty (registered)
//   fifo_count  out  occupied entries, 0..DEPTH
//   overflow    out  sticky, a byte was dropped; cleared only by rst
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 5,
  parameter int WR_LAG       = 1,
  parameter int EOL_EN       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        data_i,
  output logic              tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Write strobe and end-of-line insertion
  // ---------------------------------------------------------------------------
  logic       wr_en_q;
  logic       wstb;
  logic       wstb_q;
  logic       eol_cr;     // falling edge of the strobe: push 0x0D this cycle
  logic       eol_lf;     // cycle after the falling edge: push 0x0A
  logic       push_req;
  logic [7:0] push_data;
  logic       eol_clash;  // producer byte lost to the LF push

  // With WR_LAG the producer's data trails its enable by one cycle, so the
  // strobe is taken from the registered enable.
  assign wstb   = (WR_LAG != 0) ? wr_en_q : wr_en;
  assign eol_cr = (EOL_EN != 0) && wstb_q && !wstb;

  // NOTE: combinational blocks assign every output a default first so that
  // no path leaves a signal unassigned and infers a latch.
  always_comb begin
    push_req  = 1'b0;
    push_data = data_i;
    eol_clash = 1'b0;
    if (eol_cr) begin
      // The strobe is low in this cycle by definition, so nothing collides.
      push_req  = 1'b1;
      push_data = 8'h0D;
    end else if (eol_lf) begin
      push_req  = 1'b1;
      push_data = 8'h0A;
      eol_clash = wstb;
    end else if (wstb) begin
      push_req  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_n;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push_ok;
  logic              push_drop;

  state_t            state;
  state_t            state_n;

  assign full  = (fifo_count == FULL_CNT);
  assign empty = (fifo_count == '0);
  assign pop   = (state == IDLE) && !empty;

  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is still accepted then.
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = (push_req && !push_ok) || eol_clash;

  always_comb begin
    count_n = fifo_count;
    if (push_ok && !pop) begin
      count_n = fifo_count + 1'b1;
    end else if (pop && !push_ok) begin
      count_n = fifo_count - 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      wstb_q   <= 1'b0;
      eol_lf   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en_q <= wr_en;
      wstb_q  <= wstb;
      eol_lf  <= eol_cr;
      if (push_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= count_n;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM: state register
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_done;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic [7:0]       shreg;
  logic             tx_n;
  logic             busy_n;

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!empty)                       state_n = START;
      START: if (baud_done)                    state_n = DATA;
      DATA:  if (baud_done && bit_idx == 3'd7) state_n = STOP;
      STOP:  if (baud_done)                    state_n = IDLE;
      default:                                 state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Baud counter, bit index and shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_idx_n = bit_idx;
    if (state != DATA) begin
      bit_idx_n = 3'd0;
    end else if (baud_done) begin
      bit_idx_n = bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      // Restart the bit timer on every state change and every data-bit change.
      if (state == IDLE || state_n != state || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      bit_idx <= bit_idx_n;
      if (pop) begin
        shreg <= mem[rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM: outputs
  // tx and busy are computed from next-cycle values and registered, so the
  // pin changes together with the state and busy cannot glitch in the
  // one-cycle IDLE gap between back-to-back frames (the FIFO count is still
  // non-zero there).
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      tx   <= tx_n;
      busy <= busy_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two instances share one clock:
//   u_a  DEPTH=32, WR_LAG=1, EOL_EN=1  (report bursts with CR/LF)
//   u_b  DEPTH=4,  WR_LAG=0, EOL_EN=0  (single bytes, overflow, wrap, reset)
// A transaction-level model per instance (a byte queue plus a frame-time
// countdown) predicts tx, busy, fifo_count and overflow after every edge.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, wr_a, tx_a, busy_a, ovf_a;
  logic [7:0] din_a;
  logic [5:0] cnt_a;
  logic       rst_b, wr_b, tx_b, busy_b, ovf_b;
  logic [7:0] din_b;
  logic [2:0] cnt_b;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB), .DEPTH(32), .ADDR_W(5), .WR_LAG(1), .EOL_EN(1)
  ) u_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_a), .data_i(din_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .overflow(ovf_a)
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB), .DEPTH(4), .ADDR_W(2), .WR_LAG(0), .EOL_EN(0)
  ) u_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_b), .data_i(din_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b), .overflow(ovf_b)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (index 0 = u_a, 1 = u_b)
  // ---------------------------------------------------------------------------
  int         m_depth [2] = '{32, 4};
  bit         m_lag   [2] = '{1'b1, 1'b0};
  bit         m_eol   [2] = '{1'b1, 1'b0};
  logic [7:0] m_q     [2][$];   // bytes waiting in the FIFO
  logic [7:0] m_eolq  [2][$];   // pending end-of-line bytes
  int         m_left  [2];      // cycles left in the frame on the line
  logic [7:0] m_cur   [2];      // byte on the line
  bit         m_ovf   [2];
  bit         m_wr_q  [2];
  bit         m_wstb_q[2];

  function automatic void model_step(int k, bit r, bit we, logic [7:0] d);
    bit         wstb;
    bit         do_pop;
    bit         has_push;
    logic [7:0] pb;
    if (r) begin
      m_q[k].delete();
      m_eolq[k].delete();
      m_left[k]   = 0;
      m_ovf[k]    = 1'b0;
      m_wr_q[k]   = 1'b0;
      m_wstb_q[k] = 1'b0;
      return;
    end
    wstb     = m_lag[k] ? m_wr_q[k] : we;
    do_pop   = (m_left[k] == 0) && (m_q[k].size() > 0);
    has_push = 1'b0;
    pb       = d;
    if (m_eol[k] && m_wstb_q[k] && !wstb) begin
      m_eolq[k].push_back(8'h0D);
      m_eolq[k].push_back(8'h0A);
    end
    if (m_eolq[k].size() > 0) begin
      pb       = m_eolq[k].pop_front();
      has_push = 1'b1;
      if (wstb) m_ovf[k] = 1'b1;
    end else if (wstb) begin
      has_push = 1'b1;
    end
    if (do_pop) begin
      m_cur[k]  = m_q[k].pop_front();
      m_left[k] = FRAME;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
    end
    if (has_push) begin
      if (m_q[k].size() < m_depth[k]) m_q[k].push_back(pb);
      else                            m_ovf[k] = 1'b1;
    end
    m_wr_q[k]   = we;
    m_wstb_q[k] = wstb;
  endfunction

  // Line level from the position inside the 10-bit frame.
  function automatic logic exp_tx(int k);
    int slot;
    if (m_left[k] == 0) return 1'b1;
    slot = (FRAME - m_left[k]) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[k][slot-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int k);
    return (m_left[k] != 0) || (m_q[k].size() != 0);
  endfunction

  always @(posedge clk) begin
    model_step(0, rst_a, wr_a, din_a);
    model_step(1, rst_b, wr_b, din_b);
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("a_tx",    tx_a,   exp_tx(0));
      check("a_busy",  busy_a, exp_busy(0));
      check("a_count", cnt_a,  m_q[0].size());
      check("a_ovf",   ovf_a,  m_ovf[0]);
      check("b_tx",    tx_b,   exp_tx(1));
      check("b_busy",  busy_b, exp_busy(1));
      check("b_count", cnt_b,  m_q[1].size());
      check("b_ovf",   ovf_b,  m_ovf[1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_b(input logic [7:0] d);
    wr_b  = 1'b1;
    din_b = d;
    @(negedge clk);
    wr_b  = 1'b0;
  endtask

  task automatic drain_b(input string tag, input int budget);
    int n = 0;
    while (busy_b && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_b, 1'b0);
  endtask

  task automatic drain_a(input string tag, input int budget);
    int n = 0;
    while (busy_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_a, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] s [21];
    int         n;
    int         max_cnt;

    rst_a = 1'b1; wr_a = 1'b0; din_a = 8'h00;
    rst_b = 1'b1; wr_b = 1'b0; din_b = 8'h00;
    @(negedge clk);
    chk_on = 1'b1;
    check("rst_a_tx",    tx_a,   1'b1);
    check("rst_a_busy",  busy_a, 1'b0);
    check("rst_a_count", cnt_a,  0);
    check("rst_a_ovf",   ovf_a,  1'b0);
    check("rst_b_tx",    tx_b,   1'b1);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);

    // --- u_b: single 0x61; busy spans pop cycle + 40 frame cycles ----------
    push_b(8'h61);
    n = 0;
    while (busy_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b61_busy_len", n, 41);
    repeat (5) @(negedge clk);

    // --- u_b: 6 bytes back-to-back into DEPTH=4 -> 0x06 dropped -------------
    for (int i = 1; i <= 6; i++) begin
      wr_b  = 1'b1;
      din_b = 8'(i);
      @(negedge clk);
    end
    wr_b = 1'b0;
    check("b_ovf_set",   ovf_b, 1'b1);
    check("b_full_cnt",  cnt_b, 4);
    drain_b("b_ovf_drain", 400);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_ovf_clear", ovf_b, 1'b0);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // --- u_b: push into a full FIFO exactly at the pop edge -----------------
    for (int i = 0; i < 5; i++) begin
      wr_b  = 1'b1;
      din_b = 8'h10 + 8'(i);
      @(negedge clk);
    end
    wr_b = 1'b0;
    n = 0;
    while (m_left[1] != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_full_before", cnt_b, 4);
    push_b(8'hAA);
    check("b_full_pop_cnt", cnt_b, 4);
    check("b_full_pop_ovf", ovf_b, 1'b0);
    drain_b("b_full_drain", 400);

    // --- u_b: reset during data bit 3 of 0x55 -------------------------------
    push_b(8'h55);
    n = 0;
    while (m_left[1] != FRAME - 17 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b55_bit3", tx_b, 1'b0);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("b_midrst_tx",    tx_b,   1'b1);
    check("b_midrst_count", cnt_b,  0);
    check("b_midrst_busy",  busy_b, 1'b0);
    push_b(8'h33);
    drain_b("b33_drain", 100);

    // --- u_b: 40 random bytes below line rate, pointers wrap ----------------
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      push_b(8'($urandom_range(0, 255)));
      for (int j = 0; j < 44; j++) begin
        if (int'(cnt_b) > max_cnt) max_cnt = int'(cnt_b);
        @(negedge clk);
      end
    end
    drain_b("b_wrap_drain", 200);
    check("b_wrap_max_le4", (max_cnt <= 4), 1'b1);
    check("b_wrap_ovf",     ovf_b,          1'b0);

    // --- u_a: 21-byte report with lagged data, plus CR/LF -------------------
    for (int j = 0; j < 21; j++) begin
      s[j] = (j % 11 == 0) ? 8'h61 + 8'(j / 11) : 8'h30 + 8'((j % 11) - 1);
    end
    wr_a  = 1'b1;
    din_a = 8'hEE;          // stale byte in the first enable cycle
    @(negedge clk);
    for (int j = 0; j < 21; j++) begin
      wr_a  = (j < 20);
      din_a = s[j];
      @(negedge clk);
    end
    wr_a  = 1'b0;
    din_a = 8'h00;
    @(negedge clk);
    check("a_burst_ovf", ovf_a, 1'b0);
    drain_a("a_burst_drain", 2000);

    // --- u_a: random bursts, some gaps short enough to hit the CR/LF window -
    for (int b = 0; b < 12; b++) begin
      int len;
      int gap;
      len = $urandom_range(1, 6);
      gap = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(50, 400);
      for (int j = 0; j < len; j++) begin
        wr_a  = 1'b1;
        din_a = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      wr_a = 1'b0;
      repeat (gap) @(negedge clk);
    end
    drain_a("a_rand_drain", 5000);
    check("a_final_count", cnt_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
